// File: rtl/ibex_msg_pkg.sv
// ibex_msg_pkg
// Shared definitions for the message ingress path that feeds the MPRF.
//   msg_ingress_state_e : ingress FSM states
//   MsgLenLsb/MsgLenMsb : position of the "payload words - 1" field in a header flit
//   MsgMaxWords         : largest payload the 2-bit length field can describe
//   MsgWordsWidth       : width of the word-count output (holds 1..MsgMaxWords)
package ibex_msg_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PAYLOAD = 2'd1,
    S_DROP    = 2'd2,
    S_WAIT    = 2'd3
  } msg_ingress_state_e;

  localparam int unsigned MsgLenLsb     = 0;
  localparam int unsigned MsgLenMsb     = 1;
  localparam int unsigned MsgMaxWords   = 4;
  localparam int unsigned MsgWordsWidth = 3;

endpackage

// File: rtl/ibex_msg_ingress.sv
// ibex_msg_ingress
// Accepts message flits from the network, decodes the header length, writes
// payload words into consecutive MPRF entries starting at MsgBase, then holds
// the message as pending (and stalls the network) until the core acknowledges.
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   net_valid_i/ready_o    network flit handshake
//   net_data_i, net_last_i flit payload and end-of-message marker
//   input_valid_o/addr_o/data_o  MPRF input write port (one pulse per word)
//   len_o                  header length field of the current message
//   msg_pending_o          complete message resident in MPRF
//   msg_words_o            number of words actually written
//   msg_ack_i              core has consumed the message
//   err_o                  one-cycle protocol-error pulse
module ibex_msg_ingress
  import ibex_msg_pkg::*;
#(
  parameter int unsigned DataWidth = 32,
  parameter logic [4:0]  MsgBase   = 5'd1,
  parameter int unsigned MaxWords  = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     net_valid_i,
  output logic                     net_ready_o,
  input  logic [DataWidth-1:0]     net_data_i,
  input  logic                     net_last_i,
  output logic                     input_valid_o,
  output logic [4:0]               input_addr_o,
  output logic [DataWidth-1:0]     input_data_o,
  output logic [1:0]               len_o,
  output logic                     msg_pending_o,
  output logic [MsgWordsWidth-1:0] msg_words_o,
  input  logic                     msg_ack_i,
  output logic                     err_o
);

  // MPRF[0] is hardwired zero and the write address must never wrap past 31.
  if ((MsgBase == 5'd0) || (MaxWords == 0) || (MaxWords > MsgMaxWords) ||
      ((32'(MsgBase) + MaxWords) > 32)) begin : gen_bad_cfg
    $error("ibex_msg_ingress: illegal MsgBase/MaxWords combination");
  end

  // Index of the last word this instance may write.
  localparam logic [1:0] LastIdx = 2'(MaxWords - 1);

  msg_ingress_state_e       state_q, state_d;
  logic [1:0]               len_q, len_d;
  logic [2:0]               cnt_q, cnt_d;
  logic                     net_ready_q, net_ready_d;
  logic                     input_valid_q, input_valid_d;
  logic [4:0]               input_addr_q, input_addr_d;
  logic [DataWidth-1:0]     input_data_q, input_data_d;
  logic                     msg_pending_q, msg_pending_d;
  logic [MsgWordsWidth-1:0] msg_words_q, msg_words_d;
  logic                     err_q, err_d;

  logic       accept;
  logic [1:0] last_idx;
  logic       at_end;

  assign accept = net_valid_i && net_ready_q;

  // The header length is clamped to what the instance can hold, so a build
  // with a smaller MaxWords treats longer headers as overlong messages.
  assign last_idx = (len_q < LastIdx) ? len_q : LastIdx;
  assign at_end   = (cnt_q == {1'b0, last_idx});

  // Next-state and next-output computation for the ingress FSM. Every output
  // is computed here and registered below, so consumers only see flop outputs.
  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    cnt_d         = cnt_q;
    input_valid_d = 1'b0;
    input_addr_d  = input_addr_q;
    input_data_d  = input_data_q;
    msg_pending_d = msg_pending_q;
    msg_words_d   = msg_words_q;
    err_d         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (net_last_i) begin
            // A header with no payload is a protocol error; nothing to store.
            err_d = 1'b1;
          end else begin
            len_d   = net_data_i[MsgLenMsb:MsgLenLsb];
            cnt_d   = '0;
            state_d = S_PAYLOAD;
          end
        end
      end

      S_PAYLOAD: begin
        if (accept) begin
          input_valid_d = 1'b1;
          input_addr_d  = MsgBase + 5'(cnt_q);
          input_data_d  = net_data_i;
          cnt_d         = cnt_q + 3'd1;
          if (net_last_i) begin
            // Normal end, or truncated if the header promised more words.
            state_d     = S_WAIT;
            msg_words_d = cnt_q + 3'd1;
            err_d       = !at_end;
          end else if (at_end) begin
            // Overlong: this word is kept, the rest is drained in S_DROP.
            state_d     = S_DROP;
            msg_words_d = cnt_q + 3'd1;
            err_d       = 1'b1;
          end
        end
      end

      S_DROP: begin
        if (accept && net_last_i) begin
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        // Pending rises one cycle after entry, i.e. after the final write
        // strobe has been presented to the MPRF.
        msg_pending_d = 1'b1;
        if (msg_ack_i) begin
          state_d       = S_IDLE;
          msg_pending_d = 1'b0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Ready is registered from the next state so the network is stalled from
  // the very cycle the FSM enters S_WAIT.
  assign net_ready_d = (state_d != S_WAIT);

  // State and registered outputs; reset drops any in-flight message.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= S_IDLE;
      len_q         <= '0;
      cnt_q         <= '0;
      net_ready_q   <= 1'b0;
      input_valid_q <= 1'b0;
      input_addr_q  <= '0;
      input_data_q  <= '0;
      msg_pending_q <= 1'b0;
      msg_words_q   <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      cnt_q         <= cnt_d;
      net_ready_q   <= net_ready_d;
      input_valid_q <= input_valid_d;
      input_addr_q  <= input_addr_d;
      input_data_q  <= input_data_d;
      msg_pending_q <= msg_pending_d;
      msg_words_q   <= msg_words_d;
      err_q         <= err_d;
    end
  end

  assign net_ready_o   = net_ready_q;
  assign input_valid_o = input_valid_q;
  assign input_addr_o  = input_addr_q;
  assign input_data_o  = input_data_q;
  assign len_o         = len_q;
  assign msg_pending_o = msg_pending_q;
  assign msg_words_o   = msg_words_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_ibex_msg_ingress.sv
// tb_ibex_msg_ingress
// Self-checking bench for ibex_msg_ingress: directed scenarios plus randomized
// messages compared against a length/count model of the ingress rules.
module tb_ibex_msg_ingress;
  import ibex_msg_pkg::*;

  localparam int DW = 32;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b1;
  logic          net_valid_i = 1'b0;
  logic          net_last_i = 1'b0;
  logic          msg_ack_i = 1'b0;
  logic [DW-1:0] net_data_i = '0;
  logic          net_ready_o;
  logic          input_valid_o;
  logic [4:0]    input_addr_o;
  logic [DW-1:0] input_data_o;
  logic [1:0]    len_o;
  logic          msg_pending_o;
  logic [2:0]    msg_words_o;
  logic          err_o;

  ibex_msg_ingress #(.DataWidth(DW), .MsgBase(5'd1), .MaxWords(4)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .net_valid_i   (net_valid_i),
    .net_ready_o   (net_ready_o),
    .net_data_i    (net_data_i),
    .net_last_i    (net_last_i),
    .input_valid_o (input_valid_o),
    .input_addr_o  (input_addr_o),
    .input_data_o  (input_data_o),
    .len_o         (len_o),
    .msg_pending_o (msg_pending_o),
    .msg_words_o   (msg_words_o),
    .msg_ack_i     (msg_ack_i),
    .err_o         (err_o)
  );

  always #5 clk_i = ~clk_i;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // Observations gathered just after each rising edge.
  logic [4:0]  wa[$];
  logic [31:0] wd[$];
  int          wt[$];
  logic [1:0]  wl[$];
  int          err_cnt = 0;
  int          err_cyc = -1;
  int          pend_cyc = -1;
  logic        pend_prev = 1'b0;
  logic [31:0] pay[8];

  always @(posedge clk_i) cyc <= cyc + 1;

  // Record every MPRF write, error pulse and pending rise with its cycle.
  always @(posedge clk_i) begin
    #1;
    if (input_valid_o === 1'b1) begin
      wa.push_back(input_addr_o);
      wd.push_back(input_data_o);
      wt.push_back(cyc);
      wl.push_back(len_o);
    end
    if (err_o === 1'b1) begin
      err_cnt = err_cnt + 1;
      err_cyc = cyc;
    end
    if (msg_pending_o === 1'b1 && pend_prev !== 1'b1) pend_cyc = cyc;
    pend_prev = msg_pending_o;
  end

  task automatic clear_obs();
    wa.delete(); wd.delete(); wt.delete(); wl.delete();
    err_cnt = 0; err_cyc = -1; pend_cyc = -1;
  endtask

  // Present one flit and wait until it is accepted; valid stays high after.
  task automatic send_flit(input logic [31:0] d, input logic l);
    bit done;
    done = 0;
    net_valid_i = 1'b1; net_data_i = d; net_last_i = l;
    for (int i = 0; i < 50 && !done; i++) begin
      if (net_ready_o === 1'b1) begin
        @(posedge clk_i);
        done = 1;
      end
      @(negedge clk_i);
    end
    if (!done) begin
      tests++; fails++;
      $display("[TB] FAIL flit_accept_timeout got no ready within 50 cycles exp ready");
    end
  endtask

  task automatic go_idle(input int n);
    net_valid_i = 1'b0; net_last_i = 1'b0;
    repeat (n) @(negedge clk_i);
  endtask

  task automatic send_msg(input int len, input int npay, input int gapmode);
    logic [31:0] hdr;
    hdr = $urandom;
    hdr[1:0] = 2'(len);
    send_flit(hdr, npay == 0);
    for (int i = 0; i < npay; i++) begin
      if (gapmode == 1 || (gapmode == 2 && $urandom_range(0, 2) == 0)) go_idle(1);
      pay[i] = $urandom;
      send_flit(pay[i], i == npay - 1);
    end
    go_idle(0);
  endtask

  task automatic wait_pending(output bit ok);
    ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      if (msg_pending_o === 1'b1) ok = 1;
      else @(negedge clk_i);
    end
  endtask

  task automatic do_ack();
    msg_ack_i = 1'b1;
    @(negedge clk_i);
    msg_ack_i = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    tests++;
    if (net_ready_o !== 1'b0) begin
      fails++; $display("[TB] FAIL reset_ready got %b exp 0", net_ready_o);
    end
    repeat (2) @(negedge clk_i);
    tests++;
    if ({input_valid_o, input_addr_o, input_data_o, len_o, msg_pending_o, msg_words_o, err_o} !== '0) begin
      fails++; $display("[TB] FAIL reset_outputs got v=%b a=%0d d=%h len=%0d p=%b w=%0d e=%b exp all 0",
                        input_valid_o, input_addr_o, input_data_o, len_o, msg_pending_o, msg_words_o, err_o);
    end
    rst_ni = 1'b1;
    @(negedge clk_i);
    tests++;
    if (net_ready_o !== 1'b1) begin
      fails++; $display("[TB] FAIL reset_release_ready got %b exp 1", net_ready_o);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int rdy_seen;
    clear_obs();
    send_flit(32'h0000_0001, 1'b0);
    send_flit(32'hAAAA_0001, 1'b0);
    send_flit(32'hBBBB_0002, 1'b1);
    go_idle(0);
    wait_pending(ok);
    tests++;
    if (!ok) begin fails++; $display("[TB] FAIL b2b_pending got 0 exp 1"); end
    tests++;
    if (wa.size() != 2) begin
      fails++; $display("[TB] FAIL b2b_write_count got %0d exp 2", wa.size());
    end else begin
      tests++;
      if (wa[0] !== 5'd1 || wd[0] !== 32'hAAAA_0001 || wa[1] !== 5'd2 || wd[1] !== 32'hBBBB_0002) begin
        fails++; $display("[TB] FAIL b2b_writes got %0d:%h %0d:%h exp 1:aaaa0001 2:bbbb0002", wa[0], wd[0], wa[1], wd[1]);
      end
      tests++;
      if (wt[1] != wt[0] + 1) begin
        fails++; $display("[TB] FAIL b2b_consecutive got cycles %0d,%0d exp adjacent", wt[0], wt[1]);
      end
      tests++;
      if (pend_cyc != wt[1] + 1) begin
        fails++; $display("[TB] FAIL b2b_pending_timing got cycle %0d exp %0d", pend_cyc, wt[1] + 1);
      end
    end
    tests++;
    if (msg_words_o !== 3'd2 || err_cnt != 0) begin
      fails++; $display("[TB] FAIL b2b_words_err got w=%0d err=%0d exp w=2 err=0", msg_words_o, err_cnt);
    end
    rdy_seen = 0;
    repeat (4) begin
      if (net_ready_o !== 1'b0) rdy_seen++;
      @(negedge clk_i);
    end
    tests++;
    if (rdy_seen != 0) begin fails++; $display("[TB] FAIL b2b_stall got ready %0d times exp 0", rdy_seen); end
    do_ack();
    tests++;
    if (msg_pending_o !== 1'b0 || net_ready_o !== 1'b1) begin
      fails++; $display("[TB] FAIL b2b_ack got p=%b r=%b exp p=0 r=1", msg_pending_o, net_ready_o);
    end
  endtask

  task automatic test_gapped_four();
    bit ok;
    clear_obs();
    send_msg(3, 4, 1);
    wait_pending(ok);
    tests++;
    if (!ok || wa.size() != 4) begin
      fails++; $display("[TB] FAIL gap4_count got pend=%b writes=%0d exp pend=1 writes=4", ok, wa.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests++;
        if (wa[i] !== 5'(i + 1) || wd[i] !== pay[i] || wl[i] !== 2'd3) begin
          fails++; $display("[TB] FAIL gap4_word%0d got %0d:%h len=%0d exp %0d:%h len=3", i, wa[i], wd[i], wl[i], i + 1, pay[i]);
        end
      end
    end
    tests++;
    if (msg_words_o !== 3'd4 || err_cnt != 0 || len_o !== 2'd3) begin
      fails++; $display("[TB] FAIL gap4_status got w=%0d err=%0d len=%0d exp w=4 err=0 len=3", msg_words_o, err_cnt, len_o);
    end
    do_ack();
  endtask

  task automatic test_truncated();
    bit ok;
    clear_obs();
    send_msg(3, 2, 0);
    wait_pending(ok);
    tests++;
    if (!ok || err_cnt != 1 || msg_words_o !== 3'd2) begin
      fails++; $display("[TB] FAIL trunc_status got pend=%b err=%0d w=%0d exp pend=1 err=1 w=2", ok, err_cnt, msg_words_o);
    end
    tests++;
    if (wa.size() != 2 || wa[0] !== 5'd1 || wa[1] !== 5'd2) begin
      fails++; $display("[TB] FAIL trunc_writes got count %0d exp 2 at addr 1,2", wa.size());
    end
    do_ack();
  endtask

  task automatic test_overlong();
    bit ok;
    clear_obs();
    send_msg(0, 3, 0);
    wait_pending(ok);
    tests++;
    if (!ok || err_cnt != 1 || msg_words_o !== 3'd1) begin
      fails++; $display("[TB] FAIL over_status got pend=%b err=%0d w=%0d exp pend=1 err=1 w=1", ok, err_cnt, msg_words_o);
    end
    tests++;
    if (wa.size() != 1 || wa[0] !== 5'd1 || wd[0] !== pay[0]) begin
      fails++; $display("[TB] FAIL over_writes got count %0d exp 1 write of %h at addr 1", wa.size(), pay[0]);
    end else begin
      tests++;
      if (err_cyc != wt[0]) begin
        fails++; $display("[TB] FAIL over_err_timing got cycle %0d exp %0d", err_cyc, wt[0]);
      end
    end
    do_ack();
  endtask

  task automatic test_ack_backpressure();
    bit ok;
    int rdy_seen;
    clear_obs();
    send_msg(0, 1, 0);
    wait_pending(ok);
    net_valid_i = 1'b1; net_data_i = 32'h1234_5601; net_last_i = 1'b0;
    rdy_seen = 0;
    repeat (5) begin
      @(negedge clk_i);
      if (net_ready_o !== 1'b0) rdy_seen++;
    end
    tests++;
    if (!ok || rdy_seen != 0 || len_o !== 2'd0 || msg_pending_o !== 1'b1) begin
      fails++; $display("[TB] FAIL bp_hold got ready=%0d len=%0d p=%b exp ready=0 len=0 p=1", rdy_seen, len_o, msg_pending_o);
    end
    do_ack();
    tests++;
    if (msg_pending_o !== 1'b0 || net_ready_o !== 1'b1 || len_o !== 2'd0) begin
      fails++; $display("[TB] FAIL bp_ack got p=%b r=%b len=%0d exp p=0 r=1 len=0", msg_pending_o, net_ready_o, len_o);
    end
    @(negedge clk_i);
    tests++;
    if (len_o !== 2'd1) begin fails++; $display("[TB] FAIL bp_header_taken got len=%0d exp 1", len_o); end
    clear_obs();
    pay[0] = $urandom; pay[1] = $urandom;
    send_flit(pay[0], 1'b0);
    send_flit(pay[1], 1'b1);
    go_idle(0);
    wait_pending(ok);
    tests++;
    if (!ok || msg_words_o !== 3'd2 || wa.size() != 2 || err_cnt != 0) begin
      fails++; $display("[TB] FAIL bp_second_msg got pend=%b w=%0d writes=%0d err=%0d exp 1,2,2,0", ok, msg_words_o, wa.size(), err_cnt);
    end
    do_ack();
  endtask

  task automatic test_reset_mid_msg();
    bit ok;
    int nwr;
    clear_obs();
    send_flit(32'h0000_0003, 1'b0);
    send_flit(32'hCAFE_0001, 1'b0);
    send_flit(32'hCAFE_0002, 1'b0);
    net_valid_i = 1'b0;
    rst_ni = 1'b0;
    #1;
    tests++;
    if ({input_valid_o, input_addr_o, input_data_o, len_o, msg_pending_o, msg_words_o, err_o, net_ready_o} !== '0) begin
      fails++; $display("[TB] FAIL midrst_outputs got v=%b a=%0d len=%0d p=%b r=%b exp all 0",
                        input_valid_o, input_addr_o, len_o, msg_pending_o, net_ready_o);
    end
    nwr = wa.size();
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);
    tests++;
    if (nwr != 2 || wa.size() != 2) begin
      fails++; $display("[TB] FAIL midrst_no_writes got %0d then %0d exp 2 then 2", nwr, wa.size());
    end
    clear_obs();
    send_msg(0, 1, 0);
    wait_pending(ok);
    tests++;
    if (!ok || wa.size() != 1 || wa[0] !== 5'd1 || msg_words_o !== 3'd1) begin
      fails++; $display("[TB] FAIL midrst_restart got pend=%b writes=%0d w=%0d exp pend=1 one write at addr 1 w=1", ok, wa.size(), msg_words_o);
    end
    do_ack();
  endtask

  // Model: a message of npay payload flits after a header of length field len
  // stores min(npay, len+1) words at 1,2,...; any mismatch of npay against
  // len+1 is one error; a bare header is one error and no message.
  task automatic test_random();
    int  len, npay, exp_n, exp_err;
    bit  ok;
    for (int m = 0; m < 24; m++) begin
      len = $urandom_range(0, 3);
      npay = $urandom_range(0, 6);
      clear_obs();
      send_msg(len, npay, 2);
      if (npay == 0) begin
        repeat (3) @(negedge clk_i);
        tests++;
        if (err_cnt != 1 || wa.size() != 0 || msg_pending_o !== 1'b0 || net_ready_o !== 1'b1) begin
          fails++; $display("[TB] FAIL rnd%0d_hdr_only got err=%0d writes=%0d p=%b r=%b exp 1,0,0,1",
                            m, err_cnt, wa.size(), msg_pending_o, net_ready_o);
        end
      end else begin
        exp_n = (npay < len + 1) ? npay : len + 1;
        exp_err = (npay != len + 1) ? 1 : 0;
        wait_pending(ok);
        tests++;
        if (!ok) begin fails++; $display("[TB] FAIL rnd%0d_pending got 0 exp 1", m); end
        tests++;
        if (wa.size() != exp_n) begin
          fails++; $display("[TB] FAIL rnd%0d_count got %0d exp %0d (len=%0d npay=%0d)", m, wa.size(), exp_n, len, npay);
        end
        for (int i = 0; i < exp_n && i < wa.size(); i++) begin
          tests++;
          if (wa[i] !== 5'(1 + i) || wd[i] !== pay[i]) begin
            fails++; $display("[TB] FAIL rnd%0d_word%0d got %0d:%h exp %0d:%h", m, i, wa[i], wd[i], 1 + i, pay[i]);
          end
        end
        tests++;
        if (err_cnt != exp_err || msg_words_o !== 3'(exp_n) || len_o !== 2'(len)) begin
          fails++; $display("[TB] FAIL rnd%0d_status got err=%0d w=%0d len=%0d exp err=%0d w=%0d len=%0d",
                            m, err_cnt, msg_words_o, len_o, exp_err, exp_n, len);
        end
        do_ack();
        tests++;
        if (msg_pending_o !== 1'b0 || net_ready_o !== 1'b1) begin
          fails++; $display("[TB] FAIL rnd%0d_ack got p=%b r=%b exp p=0 r=1", m, msg_pending_o, net_ready_o);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_gapped_four();
    test_truncated();
    test_overlong();
    test_ack_backpressure();
    test_reset_mid_msg();
    test_random();
    repeat (2) @(negedge clk_i);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog got no completion exp finish within 50000 cycles");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
